// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: 8N1 frame constants, baud select codes and the 16x tick divisor lookup.
package uart_byte_rx_pkg;
    localparam int DATA_BITS = 8;
    localparam int OSR = 16;
    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_e;
    // Rounded divide minus one; unused codes fall back to 9600.
    function automatic logic [15:0] baud_div(input int unsigned clk_freq, input logic [2:0] sel);
        int unsigned baud;
        baud = sel == BAUD_19200  ? 19200  :
               sel == BAUD_38400  ? 38400  :
               sel == BAUD_57600  ? 57600  :
               sel == BAUD_115200 ? 115200 : 9600;
        return 16'((clk_freq + baud * 8) / (baud * OSR) - 1);
    endfunction
endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial input, baud select and received-byte outputs of the UART receiver.
interface uart_byte_rx_if;
    logic [2:0] set_baud;
    logic       rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;
    modport master(output set_baud, rx, input data_byte, rx_done, frame_err, uart_state);
    modport slave(input set_baud, rx, output data_byte, rx_done, frame_err, uart_state);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every div+1 clocks, phase reset by clr.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [15:0] div,
    output logic        tick
);
    logic [15:0] cnt;
    // Tick on count zero so the first tick lands one clock after clr, at the edge itself.
    assign tick = cnt == 16'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 16'd0;
        else cnt <= (clr || cnt == div) ? 16'd0 : cnt + 16'd1;
    end
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_byte_rx_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    logic [1:0]  state;
    logic        s1, s2, s3;
    logic [15:0] div;
    logic        tick;
    logic [3:0]  btick;
    logic [2:0]  bidx;
    logic        v6, v7;
    logic [7:0]  shreg;
    logic        start, vote;
    assign start = state == IDLE && s3 && !s2;
    assign vote  = (v6 & v7) | (v6 & s2) | (v7 & s2);
    uart_baud_tick u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .div   (div),
        .tick  (tick)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.rx;
            s2 <= s1;
            s3 <= s2;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            div            <= 16'd0;
            btick          <= 4'd0;
            bidx           <= 3'd0;
            v6             <= 1'b1;
            v7             <= 1'b1;
            shreg          <= 8'h00;
            bus.data_byte  <= 8'h00;
            bus.rx_done    <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.uart_state <= 1'b0;
        end else begin
            bus.rx_done   <= 1'b0;
            bus.frame_err <= 1'b0;
            if (start) begin
                state          <= START;
                bus.uart_state <= 1'b1;
                div            <= baud_div(CLK_FREQ, bus.set_baud);
                btick          <= 4'd0;
                bidx           <= 3'd0;
            end else if (state != IDLE && tick) begin
                btick <= btick + 4'd1;
                if (btick == 4'd6) v6 <= s2;
                if (btick == 4'd7) v7 <= s2;
                case (state)
                    START: begin
                        if (btick == 4'd8 && vote) begin
                            state          <= IDLE;
                            bus.uart_state <= 1'b0;
                        end else if (btick == 4'(OSR - 1)) state <= DATA;
                    end
                    DATA: begin
                        if (btick == 4'd8) shreg <= {vote, shreg[7:1]};
                        if (btick == 4'(OSR - 1)) begin
                            bidx <= bidx + 3'd1;
                            if (bidx == 3'(DATA_BITS - 1)) state <= STOP;
                        end
                    end
                    STOP: begin
                        // Leave mid stop bit so a start edge right after it is caught.
                        if (btick == 4'd8) begin
                            state          <= IDLE;
                            bus.uart_state <= 1'b0;
                            if (vote) begin
                                bus.data_byte <= shreg;
                                bus.rx_done   <= 1'b1;
                            end else bus.frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
